// File: rtl/mm_host_ctrl_if.sv
// rtl/mm_host_ctrl_if.sv - host, SRAM, DUT-handshake and result-stream signal bundle
// master = controller side, slave = environment side.
interface mm_host_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              load_valid;
  logic              load_ready;
  logic              load_sel;
  logic [DATA_W-1:0] load_data;
  logic              host_start;
  logic              host_busy;
  logic              job_done;
  logic [1:0]        job_err;
  logic              sram_input_write_enable;
  logic [ADDR_W-1:0] sram_input_write_address;
  logic [DATA_W-1:0] sram_input_write_data;
  logic              sram_weight_write_enable;
  logic [ADDR_W-1:0] sram_weight_write_address;
  logic [DATA_W-1:0] sram_weight_write_data;
  logic [ADDR_W-1:0] sram_result_read_address;
  logic [DATA_W-1:0] sram_result_read_data;
  logic              dut_valid;
  logic              dut_ready;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  modport master (
    input  load_valid, load_sel, load_data, host_start, sram_result_read_data,
           dut_ready, res_ready,
    output load_ready, host_busy, job_done, job_err,
           sram_input_write_enable, sram_input_write_address, sram_input_write_data,
           sram_weight_write_enable, sram_weight_write_address, sram_weight_write_data,
           sram_result_read_address, dut_valid, res_valid, res_data, res_last
  );

  modport slave (
    output load_valid, load_sel, load_data, host_start, sram_result_read_data,
           dut_ready, res_ready,
    input  load_ready, host_busy, job_done, job_err,
           sram_input_write_enable, sram_input_write_address, sram_input_write_data,
           sram_weight_write_enable, sram_weight_write_address, sram_weight_write_data,
           sram_result_read_address, dut_valid, res_valid, res_data, res_last
  );
endinterface

// File: rtl/mm_host_ctrl.sv
// rtl/mm_host_ctrl.sv - matrix-multiply host controller: SRAM loading, DUT kick, result drain
// Loads input/weight SRAMs, starts the accelerator, then streams NUM_MATS*in_rows*w_cols results.
module mm_host_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int NUM_MATS    = 3,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic          clk,
  input  logic          reset,
  mm_host_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, KICK, WAIT_LOW, WAIT_HIGH, DRAIN, DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_e            state_q;
  logic [ADDR_W-1:0] in_addr_q, w_addr_q, rd_addr_q;
  logic [15:0]       in_rows_q, w_cols_q;
  logic [ADDR_W:0]   n_q, iss_cnt_q;
  logic [31:0]       tmo_q;
  logic [1:0]        err_q;
  logic              done_q;
  logic              inflight_q, inflight_last_q;
  logic [DATA_W-1:0] buf_data_q [2];
  logic              buf_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;

  logic        ld_acc, start_acc, in_we, w_we, pop, issue, timed_out, size_bad;
  logic [47:0] n_full;
  logic [2:0]  fill_after;

  assign ld_acc    = bus.load_valid && (state_q == IDLE);
  assign start_acc = bus.host_start && (state_q == IDLE) && !bus.load_valid;
  assign in_we     = ld_acc && !bus.load_sel;
  assign w_we      = ld_acc && bus.load_sel;

  assign n_full    = 48'(NUM_MATS) * 48'(in_rows_q) * 48'(w_cols_q);
  assign size_bad  = (n_full == 48'd0) || (n_full > (48'd1 << ADDR_W));
  assign timed_out = (tmo_q == 32'(TIMEOUT_CYC - 1));

  // A read issued now lands in the buffer at the end of next cycle; only issue if a slot
  // is guaranteed even when nothing drains in that cycle.
  assign pop        = (occ_q != 2'd0) && bus.res_ready;
  assign fill_after = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == DRAIN) && (iss_cnt_q < n_q) && (fill_after <= 3'd1);

  assign bus.load_ready                = (state_q == IDLE);
  assign bus.host_busy                 = (state_q != IDLE);
  assign bus.job_done                  = done_q;
  assign bus.job_err                   = err_q;
  assign bus.sram_input_write_enable   = in_we;
  assign bus.sram_input_write_address  = in_addr_q;
  assign bus.sram_input_write_data     = in_we ? bus.load_data : '0;
  assign bus.sram_weight_write_enable  = w_we;
  assign bus.sram_weight_write_address = w_addr_q;
  assign bus.sram_weight_write_data    = w_we ? bus.load_data : '0;
  assign bus.sram_result_read_address  = rd_addr_q;
  assign bus.dut_valid                 = (state_q == KICK) && bus.dut_ready && !timed_out;
  assign bus.res_valid                 = (occ_q != 2'd0);
  assign bus.res_data                  = buf_data_q[rd_ptr_q];
  assign bus.res_last                  = (occ_q != 2'd0) && buf_last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      in_addr_q       <= '0;
      w_addr_q        <= '0;
      rd_addr_q       <= '0;
      in_rows_q       <= '0;
      w_cols_q        <= '0;
      n_q             <= '0;
      iss_cnt_q       <= '0;
      tmo_q           <= '0;
      err_q           <= 2'd0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
    end else begin
      done_q <= 1'b0;

      if (in_we) begin
        in_addr_q <= in_addr_q + ADDR_ONE;
        if (in_addr_q == '0) in_rows_q <= bus.load_data[31:16];
      end
      if (w_we) begin
        w_addr_q <= w_addr_q + ADDR_ONE;
        if (w_addr_q == '0) w_cols_q <= bus.load_data[15:0];
      end

      // Skid buffer: capture returning read data, retire on transfer.
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= bus.sram_result_read_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q           <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      inflight_q      <= issue;
      inflight_last_q <= issue && (iss_cnt_q == n_q - CNT_ONE);
      if (issue) begin
        rd_addr_q <= rd_addr_q + ADDR_ONE;
        iss_cnt_q <= iss_cnt_q + CNT_ONE;
      end

      case (state_q)
        IDLE: begin
          if (start_acc) begin
            if (size_bad) begin
              err_q  <= 2'd1;
              done_q <= 1'b1;
            end else begin
              err_q   <= 2'd0;
              n_q     <= n_full[ADDR_W:0];
              tmo_q   <= '0;
              state_q <= KICK;
            end
          end
        end
        KICK, WAIT_LOW, WAIT_HIGH: begin
          tmo_q <= tmo_q + 32'd1;
          if (timed_out) begin
            err_q   <= 2'd2;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (state_q == KICK && bus.dut_ready) begin
            state_q <= WAIT_LOW;
          end else if (state_q == WAIT_LOW && !bus.dut_ready) begin
            state_q <= WAIT_HIGH;
          end else if (state_q == WAIT_HIGH && bus.dut_ready) begin
            rd_addr_q <= '0;
            iss_cnt_q <= '0;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && buf_last_q[rd_ptr_q]) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          in_addr_q <= '0;
          w_addr_q  <= '0;
          in_rows_q <= '0;
          w_cols_q  <= '0;
          rd_addr_q <= '0;
          iss_cnt_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_host_ctrl.sv
// tb/tb_mm_host_ctrl.sv - randomized self-checking bench for mm_host_ctrl
// Inputs change 1ns after posedge; outputs are sampled on negedge inside tick().
module tb_mm_host_ctrl;
  localparam int ADDR_W = 16, DATA_W = 32, NUM_MATS = 3, TMO = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0, n_tests = 0, n_fail = 0;

  mm_host_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mm_host_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_MATS(NUM_MATS), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] res_mem [256];
  always @(posedge clk) bus.sram_result_read_data <= res_mem[bus.sram_result_read_address[7:0]];

  int          dv_cnt, jd_cnt, jd_cyc, xfer, exp_n, first_vc, last_xc, rise_cyc;
  int          in_wcnt, w_wcnt, dm_low, rr_mode;
  bit          dm_pending, dm_never_drop, stalled;
  logic [31:0] held;
  logic [31:0] in_exp[$], w_exp[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    logic [31:0] e;
    if (reset) return;
    if (bus.dut_valid) begin dv_cnt++; dm_pending = 1; end
    if (bus.job_done) begin jd_cnt++; jd_cyc = cyc; end
    if (bus.sram_input_write_enable) begin
      e = (in_exp.size() != 0) ? in_exp.pop_front() : 32'hDEAD_BEEF;
      check_eq("in_waddr", 64'(bus.sram_input_write_address), 64'(in_wcnt));
      check_eq("in_wdata", 64'(bus.sram_input_write_data), 64'(e));
      in_wcnt++;
    end else if (bus.load_valid) check_eq("in_wdata_idle", 64'(bus.sram_input_write_data), 0);
    if (bus.sram_weight_write_enable) begin
      e = (w_exp.size() != 0) ? w_exp.pop_front() : 32'hDEAD_BEEF;
      check_eq("w_waddr", 64'(bus.sram_weight_write_address), 64'(w_wcnt));
      check_eq("w_wdata", 64'(bus.sram_weight_write_data), 64'(e));
      w_wcnt++;
    end else if (bus.load_valid) check_eq("w_wdata_idle", 64'(bus.sram_weight_write_data), 0);
    if (stalled) begin
      check_eq("hold_valid", 64'(bus.res_valid), 1);
      check_eq("hold_data", 64'(bus.res_data), 64'(held));
    end
    if (bus.res_valid) begin
      if (first_vc < 0) first_vc = cyc;
      if (bus.res_ready) begin
        if (xfer < exp_n) begin
          check_eq("res_data", 64'(bus.res_data), 64'(res_mem[xfer]));
          check_eq("res_last", 64'(bus.res_last), 64'(xfer == exp_n - 1));
        end else check_eq("extra_word", 64'(xfer), 64'(exp_n - 1));
        last_xc = cyc;
        xfer++;
      end
    end
    stalled = bus.res_valid && !bus.res_ready;
    held    = bus.res_data;
  endtask

  // Accelerator model: after the start pulse drop ready for 1..4 cycles, then raise it.
  task automatic models();
    if (dm_pending) begin
      dm_pending = 0;
      if (!dm_never_drop) begin bus.dut_ready = 1'b0; dm_low = $urandom_range(1, 4); end
    end else if (dm_low != 0) begin
      dm_low--;
      if (dm_low == 0) begin bus.dut_ready = 1'b1; rise_cyc = cyc; end
    end
    case (rr_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = ~bus.res_ready;
      default: bus.res_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    models();
  endtask

  task automatic drive_loads(input int ir, input int ic, input int wr, input int wc, input bit with_w);
    logic [31:0] iw[$], ww[$];
    iw.push_back({16'(ir), 16'(ic)});
    repeat (ir * ic) iw.push_back($urandom);
    if (with_w) begin
      ww.push_back({16'(wr), 16'(wc)});
      repeat (wr * wc) ww.push_back($urandom);
    end
    while (iw.size() + ww.size() != 0) begin
      bit sel;
      if ($urandom_range(0, 3) == 0) begin bus.load_valid = 1'b0; tick(); continue; end
      sel = (iw.size() == 0) ? 1'b1 : (ww.size() == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.load_valid = 1'b1;
      bus.load_sel   = sel;
      if (sel) begin bus.load_data = ww.pop_front(); w_exp.push_back(bus.load_data); end
      else     begin bus.load_data = iw.pop_front(); in_exp.push_back(bus.load_data); end
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
  endtask

  task automatic clear_obs();
    dv_cnt = 0; jd_cnt = 0; xfer = 0; first_vc = -1; last_xc = -1; stalled = 0;
  endtask

  task automatic run_job(input int ir, input int ic, input int wc, input int rmode,
                         input bit tp, input int abort_at);
    int n, k, s;
    in_wcnt = 0; w_wcnt = 0;
    drive_loads(ir, ic, ic, wc, 1'b1);
    check_eq("in_beats", 64'(in_wcnt), 64'(1 + ir * ic));
    check_eq("w_beats", 64'(w_wcnt), 64'(1 + ic * wc));
    n = NUM_MATS * ir * wc;
    for (int i = 0; i < 256; i++) res_mem[i] = $urandom;
    exp_n = n;
    clear_obs();
    rr_mode = rmode;
    bus.host_start = 1'b1; s = cyc; tick(); bus.host_start = 1'b0;
    k = 0;
    while (jd_cnt == 0 && k < 400) begin
      if (abort_at != 0 && xfer >= abort_at) begin
        reset = 1'b1;
        tick();
        check_eq("rst_res_valid", 64'(bus.res_valid), 0);
        check_eq("rst_busy", 64'(bus.host_busy), 0);
        reset = 1'b0; stalled = 0; rr_mode = 0;
        repeat (6) tick();
        check_eq("rst_no_done", 64'(jd_cnt), 0);
        return;
      end
      tick(); k++;
    end
    repeat (3) tick();
    rr_mode = 0;
    check_eq("done_pulses", 64'(jd_cnt), 1);
    check_eq("dut_valid_pulses", 64'(dv_cnt), 1);
    check_eq("words", 64'(xfer), 64'(n));
    check_eq("job_err_ok", 64'(bus.job_err), 0);
    check_eq("idle_after", 64'(bus.host_busy), 0);
    check_eq("done_after_last", 64'(jd_cyc - last_xc), 1);
    if (tp) begin
      check_eq("first_valid_lat", 64'(first_vc - rise_cyc), 3);
      check_eq("throughput", 64'(last_xc - first_vc), 64'(n - 1));
    end
    if (s < 0) check_eq("start_cycle", 64'(s), 0);
  endtask

  initial begin
    int s, k;
    bus.load_valid = 1'b0; bus.load_sel = 1'b0; bus.load_data = '0; bus.host_start = 1'b0;
    bus.dut_ready = 1'b1; bus.res_ready = 1'b1;
    dm_low = 0; dm_pending = 0; dm_never_drop = 0; rr_mode = 0; rise_cyc = 0; held = '0;
    exp_n = 0; in_wcnt = 0; w_wcnt = 0;
    clear_obs();
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_busy0", 64'(bus.host_busy), 0);
    check_eq("rst_err0", 64'(bus.job_err), 0);
    check_eq("rst_done0", 64'(bus.job_done), 0);
    check_eq("rst_dut_valid0", 64'(bus.dut_valid), 0);
    check_eq("rst_res_valid0", 64'(bus.res_valid), 0);
    check_eq("rst_load_ready1", 64'(bus.load_ready), 1);
    check_eq("rst_in_we0", 64'(bus.sram_input_write_enable), 0);
    check_eq("rst_rd_addr0", 64'(bus.sram_result_read_address), 0);

    run_job(2, 3, 2, 0, 1'b1, 0);
    run_job(2, 3, 2, 1, 1'b0, 0);
    repeat (4) begin
      int m;
      m = $urandom_range(0, 2);
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), m, m == 0, 0);
    end

    // Accelerator never drops ready: timeout path.
    dm_never_drop = 1; in_wcnt = 0; w_wcnt = 0;
    drive_loads(2, 3, 3, 2, 1'b1);
    exp_n = 0; clear_obs();
    bus.host_start = 1'b1; s = cyc; tick(); bus.host_start = 1'b0;
    k = 0;
    while (jd_cnt == 0 && k < 200) begin tick(); k++; end
    check_eq("to_done_cycle", 64'(jd_cyc - s), 65);
    check_eq("to_err", 64'(bus.job_err), 2);
    check_eq("to_dut_valid", 64'(dv_cnt), 1);
    check_eq("to_no_read", 64'(first_vc < 0), 1);
    dm_never_drop = 0;
    repeat (2) tick();

    // Weight header missing: size error.
    in_wcnt = 0; w_wcnt = 0;
    drive_loads(2, 3, 0, 0, 1'b0);
    clear_obs();
    bus.host_start = 1'b1; s = cyc; tick(); bus.host_start = 1'b0;
    k = 0;
    while (jd_cnt == 0 && k < 20) begin tick(); k++; end
    check_eq("sz_done_cycle", 64'(jd_cyc - s), 1);
    check_eq("sz_err", 64'(bus.job_err), 1);
    repeat (4) tick();
    check_eq("sz_err_sticky", 64'(bus.job_err), 1);
    check_eq("sz_dut_valid", 64'(dv_cnt), 0);
    check_eq("sz_busy", 64'(bus.host_busy), 0);
    check_eq("sz_done_once", 64'(jd_cnt), 1);

    // Load beat and start in the same cycle: beat wins.
    clear_obs();
    bus.load_valid = 1'b1; bus.load_sel = 1'b0; bus.load_data = $urandom;
    in_exp.push_back(bus.load_data); bus.host_start = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.host_start = 1'b0; bus.load_data = '0;
    check_eq("ls_written", 64'(in_wcnt), 8);
    repeat (3) begin check_eq("ls_busy", 64'(bus.host_busy), 0); tick(); end
    check_eq("ls_no_done", 64'(jd_cnt), 0);

    // Clean reset, abort mid-drain, then a complete job.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    in_exp.delete(); w_exp.delete();
    run_job(2, 3, 2, 0, 1'b0, 5);
    in_exp.delete(); w_exp.delete();
    run_job(2, 3, 2, 0, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mm_host_ctrl.md
MM_HOST_CTRL -- requirements
Module: mm_host_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: SRAM address width.
REQ-002 Parameter DATA_W, default 32: SRAM data and stream width.
REQ-003 Parameter NUM_MATS, default 3: number of result matrices the DUT produces per job.
REQ-004 Parameter TIMEOUT_CYC, default 2**20: maximum cycles to wait for DUT completion.
REQ-005 One clock; reset is synchronous and active-high. Ports clk and reset are named as follows:
  clk  in  1  rising-edge clock;
  reset  in  1  synchronous active-high reset.
REQ-006 load_valid/load_ready/load_sel/load_data  in/out/in/in  1/1/1/DATA_W: load beat; load_sel 0 = input SRAM, 1 = weight SRAM.
REQ-007 host_start  in  1: job start request.
REQ-008 host_busy  out  1: high whenever the state is not IDLE.
REQ-009 job_done  out  1: one-cycle pulse at job end.
REQ-010 job_err  out  2: 0 = ok, 1 = size error, 2 = timeout; sticky until the next accepted start.
REQ-011 sram_input_write_enable/address/data  out  1/ADDR_W/DATA_W: input SRAM write port.
REQ-012 sram_weight_write_enable/address/data  out  1/ADDR_W/DATA_W: weight SRAM write port.
REQ-013 sram_result_read_address  out  ADDR_W; sram_result_read_data  in  DATA_W: result SRAM read port; data returns one cycle after the address.
REQ-014 dut_valid  out  1 / dut_ready  in  1: DUT start handshake.
REQ-015 res_valid/res_ready/res_data/res_last  out/in/out/out  1/1/DATA_W/1: result stream.

Function
REQ-016 States: IDLE, KICK, WAIT_LOW, WAIT_HIGH, DRAIN, DONE.
REQ-017 Load acceptance:
  - load_ready = 1 only in IDLE.
  - An accepted beat drives the selected SRAM write port combinationally, at that SRAM's address counter.
  - The selected counter then increments.
REQ-018 Header capture:
  - A beat written to input address 0 latches in_rows = data[31:16] and in_cols = data[15:0].
  - A beat written to weight address 0 latches w_rows = data[31:16] and w_cols = data[15:0].
REQ-019 If host_start and an accepted load beat occur in the same cycle, the load beat completes and host_start is ignored.
REQ-020 Start check: an accepted host_start computes N = NUM_MATS * in_rows * w_cols at full 34-bit-plus width.
  - If N == 0 or N > 2**ADDR_W: job_err = 1, job_done pulses next cycle, state stays IDLE, and dut_valid never asserts.
  - Otherwise: job_err = 0 and next state is KICK.
REQ-021 KICK:
  - dut_valid = 1 in exactly one cycle, the first KICK cycle in which dut_ready = 1; then go to WAIT_LOW.
  - While dut_ready = 0, stay in KICK with dut_valid = 0.
REQ-022 WAIT_LOW: wait for dut_ready = 0, then go to WAIT_HIGH.
REQ-023 WAIT_HIGH: wait for dut_ready = 1, then go to DRAIN.
REQ-024 Timeout:
  - A 32-bit cycle counter clears on entry to KICK.
  - Reaching TIMEOUT_CYC in KICK, WAIT_LOW or WAIT_HIGH sets job_err = 2 and goes to DONE.
REQ-025 DRAIN read side:
  - Issue result read addresses 0..N-1 in order.
  - Each address is issued only if the 2-entry output skid buffer will have space when its data returns.
REQ-026 DRAIN output side:
  - The buffer presents data in order on res_valid/res_data.
  - res_last = 1 on word N-1.
  - A word transfers when res_valid & res_ready.
  - res_valid is never withdrawn before transfer, and res_data holds stable while stalled.
REQ-027 Throughput: with res_ready held at 1, DRAIN sustains one word per cycle; first res_valid occurs 2 cycles after DRAIN entry.
REQ-028 DRAIN exits to DONE the cycle after the res_last transfer.
REQ-029 DONE (one cycle):
  - job_done = 1.
  - Clears both load address counters and all latched dimensions.
  - Returns to IDLE.
REQ-030 The SRAM write enables are 0 outside accepted load beats, and write data is driven to 0 when the enable is low.
REQ-031 A load counter reaching 2**ADDR_W-1 wraps to 0; no error is flagged.

Reset
REQ-032 On reset, the following go to 0: state = IDLE, counters, dimensions, job_err, dut_valid, res_valid, res_last, job_done, the write enables and the result read address.
REQ-033 Reset asserted mid-job (any state) aborts the job at the next edge.
  - The skid buffer is emptied.
  - No job_done pulse is produced.

Verification
REQ-034 Load input header 0x0002_0003 plus 6 words and weight header 0x0003_0002 plus 6 words, then start, with a DUT model ready -> write addresses 0..6 on each port; exactly one dut_valid pulse; N = 12 words streamed with res_last on the 12th; job_done pulses once.
REQ-035 res_ready toggled 1/0 each cycle during DRAIN -> all 12 words delivered in address order with no loss or duplication, and res_data stable while stalled.
REQ-036 Start with no weight header loaded (w_cols = 0) -> job_err = 1, job_done pulses, and dut_valid stays 0.
REQ-037 DUT model that never drops dut_ready, with TIMEOUT_CYC = 64 -> job_err = 2 and job_done at cycle 64 after KICK entry; no DRAIN reads.
REQ-038 load_valid and host_start asserted in the same cycle -> beat written; start ignored; host_busy stays 0.
REQ-039 Reset asserted during DRAIN after 5 words -> res_valid = 0 and state = IDLE the next cycle; a second full job completes correctly.
